// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: one product/quotient bit per cycle,
// with MFHI/MFLO/MTHI/MTLO service and a HI/LO hazard stall request.
module muldiv_unit #(
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  DIV0_LO = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       MulDivOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             ReadHiLoE,
  input  logic             HiSelE,
  input  logic             WriteHiE,
  input  logic             WriteLoE,
  output logic [WIDTH-1:0] HiLoOutE,
  output logic             BusyE,
  output logic             StallMD
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hiReg, loReg;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] rawA;
  logic             negA, negB, isDiv;

  logic             inSigned, inNegA, inNegB;
  logic [WIDTH-1:0] inMagA, inMagB;
  logic             lastCycle;

  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic               divGeq;
  logic [AW-1:0]      mulNext, divNext, stepNext;
  logic [2*WIDTH-1:0] prod, prodRes;
  logic [WIDTH-1:0]   quot, rem, resHi, resLo;

  // Operand magnitudes at issue; -2^(W-1) maps onto the unsigned value 2^(W-1).
  always_comb begin
    inSigned = ~MulDivOpE[0];
    inNegA   = inSigned & SrcAE[WIDTH-1];
    inNegB   = inSigned & SrcBE[WIDTH-1];
    inMagA   = inNegA ? -SrcAE : SrcAE;
    inMagB   = inNegB ? -SrcBE : SrcBE;
  end

  assign lastCycle = (count == LAST);

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    mulSum   = acc[AW-1:WIDTH] + {1'b0, magB};
    mulNext  = {1'b0, (acc[0] ? mulSum : acc[AW-1:WIDTH]), acc[WIDTH-1:1]};
    divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divDiff  = divShift - {1'b0, magB};
    divGeq   = (divShift >= {1'b0, magB});
    divNext  = {(divGeq ? divDiff : divShift), acc[WIDTH-2:0], divGeq};
    stepNext = isDiv ? divNext : mulNext;
  end

  always_comb begin
    prod    = stepNext[2*WIDTH-1:0];
    prodRes = (negA ^ negB) ? -prod : prod;
    quot    = stepNext[WIDTH-1:0];
    rem     = stepNext[2*WIDTH-1:WIDTH];
    resHi   = prodRes[2*WIDTH-1:WIDTH];
    resLo   = prodRes[WIDTH-1:0];
    if (isDiv) begin
      if (magB == '0) begin
        resHi = rawA;
        resLo = DIV0_LO;
      end else begin
        resHi = negA ? -rem : rem;
        resLo = (negA ^ negB) ? -quot : quot;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hiReg <= '0;
      loReg <= '0;
      BusyE <= 1'b0;
      acc   <= '0;
      magB  <= '0;
      rawA  <= '0;
      negA  <= 1'b0;
      negB  <= 1'b0;
      isDiv <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (StartE) begin
            acc   <= {{(WIDTH+1){1'b0}}, inMagA};
            magB  <= inMagB;
            rawA  <= SrcAE;
            negA  <= inNegA;
            negB  <= inNegB;
            isDiv <= MulDivOpE[1];
            count <= '0;
            BusyE <= 1'b1;
            state <= RUN;
          end else begin
            if (WriteHiE) hiReg <= SrcAE;
            if (WriteLoE) loReg <= SrcAE;
          end
        end
        RUN: begin
          acc <= stepNext;
          if (lastCycle) begin
            hiReg <= resHi;
            loReg <= resLo;
            count <= '0;
            BusyE <= 1'b0;
            state <= IDLE;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The final RUN cycle does not stall; the waiting request is taken once back in IDLE.
  assign StallMD  = (state == RUN) & ~lastCycle & (StartE | ReadHiLoE | WriteHiE | WriteLoE);
  assign HiLoOutE = HiSelE ? hiReg : loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, boundary divides, hazard stalls,
// MTHI/MTLO service and reset during an operation.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        StartE;
  logic [1:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        ReadHiLoE, HiSelE, WriteHiE, WriteLoE;
  logic [31:0] HiLoOutE;
  logic        BusyE, StallMD;

  int passed = 0;
  int total  = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32), .DIV0_LO('1)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .MulDivOpE(MulDivOpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ReadHiLoE(ReadHiLoE), .HiSelE(HiSelE),
    .WriteHiE(WriteHiE), .WriteLoE(WriteLoE), .HiLoOutE(HiLoOutE),
    .BusyE(BusyE), .StallMD(StallMD)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic expectHiLo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    HiSelE = 1'b1; #1;
    check({tag, "_hi"}, HiLoOutE, hi);
    HiSelE = 1'b0; #1;
    check({tag, "_lo"}, HiLoOutE, lo);
  endtask

  // Issue at the current cycle (0) and advance to cycle 33, checking BusyE on the way.
  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b; #1;
    checkBit({tag, "_stall0"}, StallMD, 1'b0);
    tick(1);
    StartE = 1'b0; #1;
    checkBit({tag, "_busy1"}, BusyE, 1'b1);
    tick(31);
    checkBit({tag, "_busy32"}, BusyE, 1'b1);
    tick(1);
    checkBit({tag, "_busy33"}, BusyE, 1'b0);
  endtask

  initial begin
    reset = 1'b1; StartE = 1'b0; MulDivOpE = 2'b00; SrcAE = '0; SrcBE = '0;
    ReadHiLoE = 1'b0; HiSelE = 1'b0; WriteHiE = 1'b0; WriteLoE = 1'b0;
    tick(2);
    checkBit("rst_busy", BusyE, 1'b0);
    checkBit("rst_stall", StallMD, 1'b0);
    expectHiLo("rst", 32'h0, 32'h0);
    reset = 1'b0;
    tick(1);

    // MULT 7,6 with BusyE and StallMD watched every cycle
    StartE = 1'b1; MulDivOpE = OP_MULT; SrcAE = 32'd7; SrcBE = 32'd6; #1;
    checkBit("m76_busy0", BusyE, 1'b0);
    tick(1);
    StartE = 1'b0; #1;
    for (int c = 1; c <= 32; c++) begin
      checkBit($sformatf("m76_busy_c%0d", c), BusyE, 1'b1);
      checkBit($sformatf("m76_stall_c%0d", c), StallMD, 1'b0);
      tick(1);
    end
    checkBit("m76_busy33", BusyE, 1'b0);
    expectHiLo("m76", 32'h0, 32'd42);

    runOp("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expectHiLo("multu_ff", 32'hFFFFFFFE, 32'h00000001);
    runOp("mult_ff", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expectHiLo("mult_ff", 32'h0, 32'h1);
    runOp("mult_n3x5", OP_MULT, 32'hFFFFFFFD, 32'd5);
    expectHiLo("mult_n3x5", 32'hFFFFFFFF, 32'hFFFFFFF1);
    runOp("div_n7_2", OP_DIV, 32'hFFFFFFF9, 32'd2);
    expectHiLo("div_n7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_7_n2", OP_DIV, 32'd7, 32'hFFFFFFFE);
    expectHiLo("div_7_n2", 32'h1, 32'hFFFFFFFD);
    runOp("divu_5_0", OP_DIVU, 32'd5, 32'd0);
    expectHiLo("divu_5_0", 32'd5, 32'hFFFFFFFF);
    runOp("div_min_0", OP_DIV, 32'h80000000, 32'd0);
    expectHiLo("div_min_0", 32'h80000000, 32'hFFFFFFFF);
    runOp("div_min_n1", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    expectHiLo("div_min_n1", 32'h0, 32'h80000000);
    runOp("multu_2p32", OP_MULTU, 32'h80000000, 32'd2);
    expectHiLo("multu_2p32", 32'h1, 32'h0);

    // MFLO issued at cycle 5 of MULT 7,6 (LO currently 0)
    StartE = 1'b1; MulDivOpE = OP_MULT; SrcAE = 32'd7; SrcBE = 32'd6; #1;
    tick(1);
    StartE = 1'b0; #1;
    for (int c = 1; c <= 4; c++) begin
      checkBit($sformatf("mflo_stall_c%0d", c), StallMD, 1'b0);
      tick(1);
    end
    ReadHiLoE = 1'b1; HiSelE = 1'b0; #1;
    for (int c = 5; c <= 31; c++) begin
      checkBit($sformatf("mflo_stall_c%0d", c), StallMD, 1'b1);
      tick(1);
    end
    checkBit("mflo_stall_c32", StallMD, 1'b0);
    check("mflo_old_c32", HiLoOutE, 32'h0);
    tick(1);
    checkBit("mflo_stall_c33", StallMD, 1'b0);
    checkBit("mflo_busy_c33", BusyE, 1'b0);
    check("mflo_val_c33", HiLoOutE, 32'd42);
    ReadHiLoE = 1'b0;

    // DIVU 100,7 then MULTU 3,3 held from cycle 1
    StartE = 1'b1; MulDivOpE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7; #1;
    tick(1);
    MulDivOpE = OP_MULTU; SrcAE = 32'd3; SrcBE = 32'd3; #1;
    for (int c = 1; c <= 31; c++) begin
      checkBit($sformatf("b2b_stall_c%0d", c), StallMD, 1'b1);
      tick(1);
    end
    checkBit("b2b_stall_c32", StallMD, 1'b0);
    checkBit("b2b_busy_c32", BusyE, 1'b1);
    tick(1);
    checkBit("b2b_stall_c33", StallMD, 1'b0);
    checkBit("b2b_busy_c33", BusyE, 1'b0);
    HiSelE = 1'b1; #1;
    check("b2b_div_hi", HiLoOutE, 32'd2);
    HiSelE = 1'b0; #1;
    check("b2b_div_lo", HiLoOutE, 32'd14);
    tick(1);
    StartE = 1'b0; #1;
    checkBit("b2b_busy_c34", BusyE, 1'b1);
    tick(32);
    checkBit("b2b_busy_c66", BusyE, 1'b0);
    expectHiLo("b2b_mul", 32'h0, 32'd9);

    // MTLO / MTHI followed by reads on the next cycle
    WriteLoE = 1'b1; SrcAE = 32'h1234; #1;
    checkBit("mtlo_stall", StallMD, 1'b0);
    tick(1);
    WriteLoE = 1'b0; ReadHiLoE = 1'b1; HiSelE = 1'b0; #1;
    check("mflo_after_mtlo", HiLoOutE, 32'h1234);
    checkBit("mflo_after_mtlo_stall", StallMD, 1'b0);
    ReadHiLoE = 1'b0; WriteHiE = 1'b1; SrcAE = 32'hABCD; #1;
    tick(1);
    WriteHiE = 1'b0; ReadHiLoE = 1'b1; HiSelE = 1'b1; #1;
    check("mfhi_after_mthi", HiLoOutE, 32'hABCD);
    ReadHiLoE = 1'b0;

    // StartE and MTHI together in IDLE: the start wins
    StartE = 1'b1; WriteHiE = 1'b1; MulDivOpE = OP_MULTU; SrcAE = 32'd2; SrcBE = 32'd3; #1;
    tick(1);
    StartE = 1'b0; WriteHiE = 1'b0; HiSelE = 1'b1; #1;
    check("prio_hi_kept", HiLoOutE, 32'hABCD);
    checkBit("prio_busy", BusyE, 1'b1);
    tick(32);
    expectHiLo("prio_res", 32'h0, 32'd6);

    // reset at cycle 10 of MULTU 9,9 aborts it
    StartE = 1'b1; MulDivOpE = OP_MULTU; SrcAE = 32'd9; SrcBE = 32'd9; #1;
    tick(1);
    StartE = 1'b0;
    tick(9);
    reset = 1'b1; #1;
    checkBit("rst_run_busy", BusyE, 1'b0);
    checkBit("rst_run_stall", StallMD, 1'b0);
    expectHiLo("rst_run", 32'h0, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(1);
    runOp("after_rst", OP_MULT, 32'd7, 32'd6);
    expectHiLo("after_rst", 32'h0, 32'd42);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
